serial_full_subtractor: RTL and testbench



---
 rtl/serial_full_subtractor.sv | 92 +++++++++
 tb/tb_serial_full_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial D = A - B - B_in, one bit per clock, LSB first
// Optional signed-overflow output OVF is built when SERIAL_SUB_OVF_EN is defined.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             OVF,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic          brw;
  logic [CW-1:0] cnt;
  logic          a0, b0, diff, brw_next, last, accept;

  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign diff     = a0 ^ b0 ^ brw;
  assign brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // a_sh doubles as the result register: each difference bit enters at the MSB
  // as the consumed minuend bit leaves at the LSB, so after WIDTH shifts it holds D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      B_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      OVF   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      brw  <= B_in;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= {diff, a_sh[WIDTH-1:1]};
      b_sh <= b_sh >> 1;
      brw  <= brw_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        D     <= {diff, a_sh[WIDTH-1:1]};
        B_out <= brw_next;
`ifdef SERIAL_SUB_OVF_EN
        // borrow into the MSB position versus borrow out of it
        OVF   <= brw ^ brw_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb/tb_serial_full_subtractor.sv - self-checking bench for serial_full_subtractor (WIDTH 8 and 4)
// Optional OVF checks follow SERIAL_SUB_OVF_EN.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst8, rst4;
  logic       start8, start4;
  logic [7:0] a8, b8, d8;
  logic [3:0] a4, b4, d4;
  logic       bin8, bin4, bout8, bout4;
  logic       busy8, busy4, done8, done4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8), .B_in(bin8),
    .D(d8), .B_out(bout8),
`ifdef SERIAL_SUB_OVF_EN
    .OVF(ovf8),
`endif
    .busy(busy8), .done(done8)
  );

  serial_full_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .B_in(bin4),
    .D(d4), .B_out(bout4),
`ifdef SERIAL_SUB_OVF_EN
    .OVF(ovf4),
`endif
    .busy(busy4), .done(done4)
  );

  function automatic int ref_d(int w, int a, int b, int bin);
    return (a - b - bin) & ((1 << w) - 1);
  endfunction

  function automatic int ref_bout(int a, int b, int bin);
    return (a < b + bin) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(int w, int a, int b, int bin);
    int sa, sb, sd;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sd = sa - sb - bin;
    return (sd < -(1 << (w - 1)) || sd > (1 << (w - 1)) - 1) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle, then scramble them to prove capture.
  task automatic drive(input bit w4, input int a, input int b, input int bin);
    if (w4) begin
      a4 = 4'(a); b4 = 4'(b); bin4 = bin[0]; start4 = 1'b1;
    end else begin
      a8 = 8'(a); b8 = 8'(b); bin8 = bin[0]; start8 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
  endtask

  // Entered at the negedge after the accepting edge; leaves in the DONE cycle.
  task automatic finish(input bit w4, input int a, input int b, input int bin);
    int w;
    int busy_cnt;
    w = w4 ? 4 : 8;
    busy_cnt = 0;
    for (int i = 0; i < w; i++) begin
      if ((w4 ? busy4 : busy8) === 1'b1 && (w4 ? done4 : done8) === 1'b0) busy_cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_cnt, w);
    chk("done_pulse", 32'(w4 ? done4 : done8), 1);
    chk("busy_in_done", 32'(w4 ? busy4 : busy8), 0);
    chk("D", w4 ? 32'(d4) : 32'(d8), ref_d(w, a, b, bin));
    chk("B_out", 32'(w4 ? bout4 : bout8), ref_bout(a, b, bin));
`ifdef SERIAL_SUB_OVF_EN
    chk("OVF", 32'(w4 ? ovf4 : ovf8), ref_ovf(w, a, b, bin));
`endif
  endtask

  initial begin
    int done_seen;
    int a, b, bin;
    rst8 = 1'b1; rst4 = 1'b1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0;
    #2;
    chk("rst_D", 32'(d8), 0);
    chk("rst_B_out", 32'(bout8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_D4", 32'(d4), 0);
    @(negedge clk);
    rst8 = 1'b0; rst4 = 1'b0;

    drive(0, 8'h5A, 8'h3C, 0);
    finish(0, 8'h5A, 8'h3C, 0);
    chk("tp1_D", 32'(d8), 32'h1E);
    @(negedge clk);
    chk("tp1_done_single", 32'(done8), 0);
    chk("tp1_D_held", 32'(d8), 32'h1E);

    drive(0, 8'h00, 8'h01, 0);
    finish(0, 8'h00, 8'h01, 0);
    chk("tp2_D", 32'(d8), 32'hFF);
    chk("tp2_B_out", 32'(bout8), 1);
    drive(0, 8'h00, 8'h00, 1);
    finish(0, 8'h00, 8'h00, 1);
    chk("tp2b_B_out", 32'(bout8), 1);
    @(negedge clk);

    // start during RUN is ignored
    drive(0, 8'h10, 8'h01, 0);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("tp3_busy", 32'(busy8), 1);
    repeat (5) @(negedge clk);
    chk("tp3_done", 32'(done8), 1);
    chk("tp3_D", 32'(d8), 32'h0F);
    chk("tp3_B_out", 32'(bout8), 0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0) done_seen++;
    end
    chk("tp3_no_second_done", done_seen, 0);

    // asynchronous reset between edges 4 and 5
    drive(0, 8'hF0, 8'h0F, 0);
    repeat (4) @(negedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("tp4_rst_D", 32'(d8), 0);
    chk("tp4_rst_B_out", 32'(bout8), 0);
    chk("tp4_rst_busy", 32'(busy8), 0);
    chk("tp4_rst_done", 32'(done8), 0);
    @(negedge clk);
    rst8 = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0) done_seen++;
    end
    chk("tp4_no_done_after_rst", done_seen, 0);
    drive(0, 8'h03, 8'h01, 0);
    finish(0, 8'h03, 8'h01, 0);
    chk("tp4_D", 32'(d8), 32'h02);
    @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
    drive(0, 8'h80, 8'h01, 0);
    finish(0, 8'h80, 8'h01, 0);
    chk("ovf1", 32'(ovf8), 1);
    drive(0, 8'h7F, 8'hFF, 0);
    finish(0, 8'h7F, 8'hFF, 0);
    chk("ovf2", 32'(ovf8), 1);
    drive(0, 8'h05, 8'h03, 0);
    finish(0, 8'h05, 8'h03, 0);
    chk("ovf3", 32'(ovf8), 0);
    @(negedge clk);
`endif

    // randomized 8-bit operations, sometimes back-to-back
    repeat (120) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      bin = int'($urandom_range(0, 1));
      drive(0, a, b, bin);
      finish(0, a, b, bin);
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        chk("rand_done_low", 32'(done8), 0);
      end
    end

    drive(1, 4'h3, 4'h5, 0);
    finish(1, 4'h3, 4'h5, 0);
    chk("tp5_D", 32'(d4), 32'hE);
    chk("tp5_B_out", 32'(bout4), 1);

    // exhaustive 4-bit sweep, chained back-to-back
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++) begin
          drive(1, i, j, k);
          finish(1, i, j, k);
        end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
